uart_mem_bridge: RTL and testbench

Byte-stream debug bridge between the UART byte layer and a dual-port block RAM. Host writes single words with byte strobes, or reads an inclusive word range streamed back LSB-first. Successor to the fixed 16-bit/32-bit loader:
- address and data widths are parametrised
- TX uses a valid/ready handshake
- writes are acknowledged
- malformed commands and stalled frames are rejected with a NAK byte

---
 rtl/uart_mem_bridge_pkg.sv | 14 +
 rtl/uart_mem_bridge_timeout.sv | 20 ++
 rtl/uart_mem_bridge.sv | 162 ++++++++++++++++
 tb/tb_uart_mem_bridge.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_bridge_pkg.sv
// uart_mem_bridge_pkg: opcodes, response bytes, FSM states and frame arg lengths for uart_mem_bridge.
package uart_mem_bridge_pkg;
  localparam logic [7:0] OP_WRITE = 8'h0F;
  localparam logic [7:0] OP_READ  = 8'hFF;
  localparam logic [7:0] OP_PING  = 8'hA5;
  localparam logic [7:0] RSP_ACK  = 8'hAC;
  localparam logic [7:0] RSP_NAK  = 8'hEE;
  localparam logic [7:0] RSP_PONG = 8'h5A;
  typedef enum logic [2:0] {IDLE, ARGS, WRITE, RD_ADDR, RD_WAIT, RD_SEND, RESP} state_t;
  function automatic int arg_len(input logic [7:0] op, input int addr_bytes, input int data_bytes, input bit chk);
    return op == OP_WRITE ? addr_bytes + 1 + data_bytes + int'(chk) :
           op == OP_READ  ? 2 * addr_bytes + int'(chk) : 0;
  endfunction
endpackage

// File: rtl/uart_mem_bridge_timeout.sv
// uart_mem_bridge_timeout: inter-byte silence counter for frames in progress.
// Ports: clk, rst_n (sync, active-low); clear restarts the count; en counts while high;
// expired is high on the TIMEOUT_CYCLES-th consecutive enabled, uncleared cycle.
module uart_mem_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign expired = en && !clear && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!rst_n || clear || !en) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: UART byte-stream debug bridge to a dual-port block RAM (write words, stream word ranges).
// Ports: clk, rst_n (sync, active-low); rx_valid/rx_data received byte strobe;
// tx_valid/tx_ready/tx_data outgoing byte handshake; mem_addra/mem_wea/mem_dia write port;
// mem_addrb/mem_dob read port (dob valid one clk after addrb); busy = FSM not IDLE.
// Build option: UART_MEM_BRIDGE_CHKSUM_EN adds XOR checksum bytes to WRITE/READ frames and READ streams.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic [8*ADDR_BYTES-1:0] mem_addra,
  output logic [DATA_BYTES-1:0]   mem_wea,
  output logic [8*DATA_BYTES-1:0] mem_dia,
  output logic [8*ADDR_BYTES-1:0] mem_addrb,
  input  logic [8*DATA_BYTES-1:0] mem_dob,
  output logic                    busy
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
`ifdef UART_MEM_BRIDGE_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int LEN_W = arg_len(OP_WRITE, ADDR_BYTES, DATA_BYTES, CHK);
  localparam int LEN_R = arg_len(OP_READ, ADDR_BYTES, DATA_BYTES, CHK);
  localparam int ARG_MAX = LEN_W > LEN_R ? LEN_W : LEN_R;
  // Args shift in from the top, so a frame of N bytes ends up left-aligned at byte ARG_MAX-N.
  localparam int WB = 8 * (ARG_MAX - LEN_W);
  localparam int RB = 8 * (ARG_MAX - LEN_R);
  state_t state;
  logic [7:0] op, cnt, axor, csum, idx;
  logic [8*ARG_MAX-9:0] arg;
  logic [8*ARG_MAX-1:0] argn;
  logic [AW-1:0] cur, last, nxt, rd_start, rd_end, diff;
  logic [DW-1:0] word, wsh;
  logic chk_ok, rd_ok, last_arg, expired, xfer;
  assign argn = {rx_data, arg};
  assign rd_start = argn[RB +: AW];
  assign rd_end = argn[RB+AW +: AW];
  assign diff = rd_end - rd_start;
  assign rd_ok = rd_end >= rd_start && (diff % AW'(DATA_BYTES)) == '0;
  // With checksums the final arg byte is the checksum; axor then holds the XOR of the bytes before it.
  assign chk_ok = !CHK || axor == argn[8*ARG_MAX-1 -: 8];
  assign last_arg = cnt == 8'(op == OP_WRITE ? LEN_W - 1 : LEN_R - 1);
  assign xfer = tx_valid && tx_ready;
  assign wsh = word >> 8;
  assign nxt = cur + AW'(DATA_BYTES);
  assign busy = state != IDLE;
  uart_mem_bridge_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst_n(rst_n), .clear(rx_valid), .en(state == ARGS), .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      cnt <= '0;
      axor <= '0;
      csum <= '0;
      idx <= '0;
      arg <= '0;
      cur <= '0;
      last <= '0;
      word <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      mem_addra <= '0;
      mem_wea <= '0;
      mem_dia <= '0;
      mem_addrb <= '0;
    end else begin
      case (state)
        IDLE: if (rx_valid) begin
          op <= rx_data;
          cnt <= '0;
          axor <= '0;
          if (rx_data == OP_WRITE || rx_data == OP_READ) state <= ARGS;
          else begin
            tx_valid <= 1'b1;
            tx_data <= rx_data == OP_PING ? RSP_PONG : RSP_NAK;
            state <= RESP;
          end
        end
        ARGS: if (rx_valid) begin
          arg <= argn[8*ARG_MAX-1:8];
          cnt <= cnt + 8'd1;
          axor <= axor ^ rx_data;
          if (last_arg) begin
            if (!chk_ok || (op == OP_READ && !rd_ok)) begin
              tx_valid <= 1'b1;
              tx_data <= RSP_NAK;
              state <= RESP;
            end else if (op == OP_WRITE) begin
              mem_addra <= argn[WB +: AW];
              mem_wea <= DATA_BYTES'(argn[WB+AW +: 8]);
              mem_dia <= argn[WB+AW+8 +: DW];
              state <= WRITE;
            end else begin
              cur <= rd_start;
              last <= rd_end;
              mem_addrb <= rd_start;
              csum <= '0;
              state <= RD_ADDR;
            end
          end
        end else if (expired) begin
          tx_valid <= 1'b1;
          tx_data <= RSP_NAK;
          state <= RESP;
        end
        WRITE: begin
          mem_wea <= '0;
          tx_valid <= 1'b1;
          tx_data <= RSP_ACK;
          state <= RESP;
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          word <= mem_dob;
          tx_data <= mem_dob[7:0];
          tx_valid <= 1'b1;
          idx <= '0;
          state <= RD_SEND;
        end
        RD_SEND: if (xfer) begin
          csum <= csum ^ tx_data;
          if (idx == 8'(DATA_BYTES - 1)) begin
            if (cur == last) begin
              // Stream checksum covers every byte sent, including the one just accepted.
              tx_valid <= CHK;
              tx_data <= csum ^ tx_data;
              state <= CHK ? RESP : IDLE;
            end else begin
              cur <= nxt;
              mem_addrb <= nxt;
              tx_valid <= 1'b0;
              state <= RD_ADDR;
            end
          end else begin
            idx <= idx + 8'd1;
            word <= wsh;
            tx_data <= wsh[7:0];
          end
        end
        RESP: if (xfer) begin
          tx_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: scoreboard bench for uart_mem_bridge with a behavioural dual-port RAM.
module tb_uart_mem_bridge;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic tx_valid, busy;
  logic [7:0] tx_data;
  logic [15:0] mem_addra, mem_addrb;
  logic [3:0] mem_wea;
  logic [31:0] mem_dia;
  logic [31:0] mem_dob = 32'h0;
  logic [31:0] ram [64] = '{default: 32'h0};
  logic [7:0] exp_q [$];
  logic [51:0] wr_q [$];
  int checks = 0, errors = 0, n_tx = 0, k = 0, base = 0;
  logic bp = 1'b0, stall_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [51:0] w;

  always #5 clk = ~clk;

  uart_mem_bridge #(.ADDR_BYTES(2), .DATA_BYTES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_addra(mem_addra), .mem_wea(mem_wea), .mem_dia(mem_dia),
    .mem_addrb(mem_addrb), .mem_dob(mem_dob), .busy(busy)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (mem_wea[i]) ram[mem_addra[7:2]][8*i +: 8] <= mem_dia[8*i +: 8];
    mem_dob <= ram[mem_addrb[7:2]];
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = bp ? (k % 3 == 0) : 1'b1;
    k++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        chk("tx_hold_valid", {63'b0, tx_valid}, 64'h1);
        chk("tx_hold_data", {56'b0, tx_data}, {56'b0, hold_data});
      end
      if (tx_valid && tx_ready) begin
        n_tx++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
        end else chk("tx_byte", {56'b0, tx_data}, {56'b0, exp_q.pop_front()});
      end
      if (mem_wea != 4'h0) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got addr 0x%0h wea 0x%0h data 0x%0h, expected no write", mem_addra, mem_wea, mem_dia);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", {48'b0, mem_addra}, {48'b0, w[51:36]});
          chk("wr_wea", {60'b0, mem_wea}, {60'b0, w[35:32]});
          chk("wr_data", {32'b0, mem_dia}, {32'b0, w[31:0]});
        end
      end
      stall_prev = tx_valid && !tx_ready;
      hold_data = tx_data;
    end
  end

  task automatic send_frame(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data = v[8*(n-1-i) +: 8];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic expect_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [3:0] we, input logic [31:0] d);
    wr_q.push_back({a, we, d});
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (!busy && !tx_valid && exp_q.size() == 0 && wr_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: still busy after %0d cycles, %0d bytes and %0d writes outstanding", name, limit, exp_q.size(), wr_q.size());
    exp_q.delete();
    wr_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", {63'b0, tx_valid}, 64'h0);
    chk("rst_tx_data", {56'b0, tx_data}, 64'h0);
    chk("rst_wea", {60'b0, mem_wea}, 64'h0);
    chk("rst_addra", {48'b0, mem_addra}, 64'h0);
    chk("rst_addrb", {48'b0, mem_addrb}, 64'h0);
    chk("rst_busy", {63'b0, busy}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_bytes(64'h5A, 1);
    send_frame(64'hA5, 1);
    wait_idle("ping", 20);
    expect_write(16'h0010, 4'hF, 32'h12345678);
    expect_bytes(64'hAC, 1);
    send_frame(64'h0F_10_00_0F_78_56_34_12, 8);
    wait_idle("write_full", 30);
    chk("ram_full", {32'b0, ram[4]}, 64'h12345678);
    expect_write(16'h0010, 4'h3, 32'hAABBCCDD);
    expect_bytes(64'hAC, 1);
    send_frame(64'h0F_10_00_03_DD_CC_BB_AA, 8);
    wait_idle("write_partial", 30);
    chk("ram_partial", {32'b0, ram[4]}, 64'h1234CCDD);
    expect_bytes(64'hAC, 1);
    send_frame(64'h0F_10_00_00_11_22_33_44, 8);
    wait_idle("write_strobe0", 30);
    chk("ram_strobe0", {32'b0, ram[4]}, 64'h1234CCDD);
    expect_write(16'h0010, 4'hF, 32'h12345678);
    expect_bytes(64'hAC, 1);
    send_frame(64'h0F_10_00_0F_78_56_34_12, 8);
    wait_idle("write_restore", 30);
    expect_write(16'h0014, 4'hF, 32'hCAFEBABE);
    expect_bytes(64'hAC, 1);
    send_frame(64'h0F_14_00_0F_BE_BA_FE_CA, 8);
    wait_idle("write_14", 30);
    expect_bytes(64'h78_56_34_12_BE_BA_FE_CA, 8);
    send_frame(64'hFF_10_00_14_00, 5);
    wait_idle("read_range", 60);
    chk("read_busy_done", {63'b0, busy}, 64'h0);
    bp = 1'b1;
    expect_bytes(64'h78_56_34_12_BE_BA_FE_CA, 8);
    send_frame(64'hFF_10_00_14_00, 5);
    wait_idle("read_backpressure", 300);
    bp = 1'b0;
    expect_bytes(64'h78_56_34_12, 4);
    send_frame(64'hFF_10_00_10_00, 5);
    wait_idle("read_single", 40);
    chk("addrb_single", {48'b0, mem_addrb}, 64'h0010);
    expect_bytes(64'hEE, 1);
    send_frame(64'hFF_14_00_10_00, 5);
    wait_idle("nak_end_lt_start", 30);
    chk("addrb_end_lt_start", {48'b0, mem_addrb}, 64'h0010);
    expect_bytes(64'hEE, 1);
    send_frame(64'hFF_10_00_12_00, 5);
    wait_idle("nak_misaligned", 30);
    chk("addrb_misaligned", {48'b0, mem_addrb}, 64'h0010);
    expect_bytes(64'hEE, 1);
    send_frame(64'h42, 1);
    wait_idle("nak_opcode", 20);
    expect_bytes(64'hEE, 1);
    send_frame(64'h0F_10, 2);
    repeat (40) @(posedge clk);
    #1;
    chk("busy_before_timeout", {63'b0, busy}, 64'h1);
    wait_idle("timeout", 100);
    chk("busy_after_timeout", {63'b0, busy}, 64'h0);
    base = n_tx;
    expect_bytes(64'h78_56_34_12_BE_BA_FE_CA, 8);
    send_frame(64'hFF_10_00_14_00, 5);
    for (int i = 0; i < 100 && n_tx < base + 3; i++) begin
      @(negedge clk);
      #1;
    end
    chk("reset_mid_stream_bytes", 64'(n_tx - base), 64'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_tx_valid", {63'b0, tx_valid}, 64'h0);
    chk("reset_wea", {60'b0, mem_wea}, 64'h0);
    chk("reset_busy", {63'b0, busy}, 64'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_bytes(64'h5A, 1);
    send_frame(64'hA5, 1);
    wait_idle("ping_after_reset", 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
